// File: rtl/spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares a single spi_16bit_master between N_REQ requesters with round-robin
// arbitration. The winning requester's configuration and TX word are
// registered onto the spi_* outputs, checked for validity, and the master is
// triggered. The master's busy handshake is tracked. The received word and a
// status code are returned with a one-cycle, one-hot ack.
//
// Optional feature (macro SPI_ARB_LOCK_EN): a requester holding req_lock keeps
// the grant for back-to-back transfers. Arbitration is skipped until the lock
// is released. When the macro is undefined, req_lock is ignored.
//
// Parameters:
//   N_REQ         number of requesters (2..8)
//   BUSY_TIMEOUT  cycles allowed after the trigger for spi_busy to rise
//
// Ports:
//   clock, port_reset              clock and synchronous active-high reset
//   req, req_lock                  per-requester request and lock
//   req_prescaler/data_count/...   per-requester config slices and TX word
//   ack, rsp_data, rsp_status      completion pulse, RX word, status
//                                  (0 ok, 1 bad config, 2 master error, 3 timeout)
//   grant                          one-hot current owner, 0 when idle
//   spi_*                          registered interface to the SPI master
// ---------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                 clock,
    input  logic                 port_reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_lock,
    input  logic [N_REQ*5-1:0]   req_prescaler,
    input  logic [N_REQ*4-1:0]   req_data_count,
    input  logic [N_REQ-1:0]     req_cpol,
    input  logic [N_REQ-1:0]     req_cpha,
    input  logic [N_REQ-1:0]     req_dir,
    input  logic [N_REQ*16-1:0]  req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          rsp_data,
    output logic [1:0]           rsp_status,
    output logic [N_REQ-1:0]     grant,
    output logic                 spi_trigger,
    output logic [4:0]           spi_prescaler,
    output logic [3:0]           spi_data_count,
    output logic                 spi_cpol,
    output logic                 spi_cpha,
    output logic                 spi_dir,
    output logic [15:0]          spi_data_out,
    input  logic [15:0]          spi_data_in,
    input  logic                 spi_busy,
    input  logic [2:0]           spi_error,
    output logic                 spi_reset
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PW-1:0]     ptr_r;
    logic [PW-1:0]     owner_r;
    logic [CW-1:0]     cnt_r;
    logic              rst_pend_r;

    logic              pick_valid_s;
    logic [PW-1:0]     pick_idx_s;
    logic [PW-1:0]     sel_idx_s;
    logic              load_cfg_s;
    logic              abort_s;
    logic              bad_cfg_s;
    logic [N_REQ-1:0]  ack_nxt_s;
    logic [N_REQ-1:0]  grant_nxt_s;
    logic [1:0]        status_nxt_s;
    logic [15:0]       data_nxt_s;
    logic [PW-1:0]     owner_nxt_s;
    logic [PW-1:0]     ptr_nxt_s;
    logic [CW-1:0]     cnt_nxt_s;
    logic [4:0]        sel_pre_s;
    logic [3:0]        sel_cnt_s;
    logic [15:0]       sel_data_s;

`ifdef SPI_ARB_LOCK_EN
    logic              lock_r;
    logic              lock_nxt_s;
`else
    logic              unused_lock_s;
    assign unused_lock_s = ^req_lock;
`endif

    // One-hot vector with the bit at idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next requester index with wrap-around at N_REQ.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        next_idx = (int'(idx) == N_REQ - 1) ? {PW{1'b0}} : idx + PW'(1);
    endfunction

    // Round-robin search: first asserted req at or after the pointer.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = {PW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j            = (int'(ptr_r) + i) % N_REQ;
            pick_idx_s   = (!pick_valid_s && req[PW'(j)]) ? PW'(j) : pick_idx_s;
            pick_valid_s = pick_valid_s | req[PW'(j)];
        end
    end

    // Mux the selected requester's config slices.
    always_comb begin
        sel_pre_s  = 5'd0;
        sel_cnt_s  = 4'd0;
        sel_data_s = 16'd0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_pre_s  = (PW'(i) == sel_idx_s) ? req_prescaler[i*5 +: 5]   : sel_pre_s;
            sel_cnt_s  = (PW'(i) == sel_idx_s) ? req_data_count[i*4 +: 4]  : sel_cnt_s;
            sel_data_s = (PW'(i) == sel_idx_s) ? req_data[i*16 +: 16]      : sel_data_s;
        end
    end

    // The master cannot run a transfer this short or with this clock ratio.
    assign bad_cfg_s = (spi_data_count <= 4'd2) || (spi_prescaler < 5'd2);

    // State register.
    always_ff @(posedge clock) begin
        if (port_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
`ifdef SPI_ARB_LOCK_EN
                if (lock_r) begin
                    state_nxt_s = req[owner_r] ? CHECK : IDLE;
                end else begin
                    state_nxt_s = pick_valid_s ? CHECK : IDLE;
                end
`else
                state_nxt_s = pick_valid_s ? CHECK : IDLE;
`endif
            end
            CHECK:     state_nxt_s = bad_cfg_s ? DONE : LAUNCH;
            LAUNCH:    state_nxt_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (spi_error != 3'd0) begin
                    state_nxt_s = DONE;
                end else if (spi_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (cnt_r <= CW'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: state_nxt_s = spi_busy ? WAIT_DONE : DONE;
            DONE:      state_nxt_s = IDLE;
            default:   state_nxt_s = IDLE;
        endcase
    end

    // Output/datapath next values; everything is registered below.
    always_comb begin
        load_cfg_s   = 1'b0;
        abort_s      = 1'b0;
        sel_idx_s    = pick_idx_s;
        grant_nxt_s  = grant;
        status_nxt_s = rsp_status;
        data_nxt_s   = rsp_data;
        owner_nxt_s  = owner_r;
        ptr_nxt_s    = ptr_r;
        cnt_nxt_s    = cnt_r;
`ifdef SPI_ARB_LOCK_EN
        lock_nxt_s   = lock_r;
`endif
        case (state_r)
            IDLE: begin
`ifdef SPI_ARB_LOCK_EN
                if (lock_r) begin
                    if (req[owner_r]) begin
                        load_cfg_s = 1'b1;
                        sel_idx_s  = owner_r;
                        lock_nxt_s = 1'b0;
                    end else begin
                        // Lock released: drop grant, advance pointer past owner.
                        lock_nxt_s  = 1'b0;
                        grant_nxt_s = {N_REQ{1'b0}};
                        ptr_nxt_s   = next_idx(owner_r);
                    end
                end else if (pick_valid_s) begin
                    load_cfg_s  = 1'b1;
                    owner_nxt_s = pick_idx_s;
                    grant_nxt_s = onehot(pick_idx_s);
                end else begin
                    grant_nxt_s = {N_REQ{1'b0}};
                end
`else
                if (pick_valid_s) begin
                    load_cfg_s  = 1'b1;
                    owner_nxt_s = pick_idx_s;
                    grant_nxt_s = onehot(pick_idx_s);
                end else begin
                    grant_nxt_s = {N_REQ{1'b0}};
                end
`endif
            end
            CHECK: begin
                if (bad_cfg_s) begin
                    status_nxt_s = 2'd1;
                end else begin
                    status_nxt_s = rsp_status;
                end
            end
            LAUNCH: cnt_nxt_s = CW'(BUSY_TIMEOUT);
            WAIT_BUSY: begin
                if (spi_error != 3'd0) begin
                    status_nxt_s = 2'd2;
                    abort_s      = 1'b1;
                end else if (spi_busy) begin
                    cnt_nxt_s = cnt_r;
                end else if (cnt_r <= CW'(1)) begin
                    status_nxt_s = 2'd3;
                    abort_s      = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    data_nxt_s   = spi_data_in;
                    status_nxt_s = 2'd0;
                end else begin
                    data_nxt_s = rsp_data;
                end
            end
            DONE: begin
`ifdef SPI_ARB_LOCK_EN
                if (req_lock[owner_r]) begin
                    lock_nxt_s = 1'b1;
                end else begin
                    grant_nxt_s = {N_REQ{1'b0}};
                    ptr_nxt_s   = next_idx(owner_r);
                end
`else
                grant_nxt_s = {N_REQ{1'b0}};
                ptr_nxt_s   = next_idx(owner_r);
`endif
            end
            default: grant_nxt_s = {N_REQ{1'b0}};
        endcase
        ack_nxt_s = (state_nxt_s == DONE) ? onehot(owner_r) : {N_REQ{1'b0}};
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clock) begin
        if (port_reset) begin
            ack            <= {N_REQ{1'b0}};
            grant          <= {N_REQ{1'b0}};
            rsp_data       <= 16'd0;
            rsp_status     <= 2'd0;
            spi_trigger    <= 1'b0;
            spi_prescaler  <= 5'd0;
            spi_data_count <= 4'd0;
            spi_cpol       <= 1'b0;
            spi_cpha       <= 1'b0;
            spi_dir        <= 1'b0;
            spi_data_out   <= 16'd0;
            spi_reset      <= 1'b1;
            rst_pend_r     <= 1'b1;
            ptr_r          <= {PW{1'b0}};
            owner_r        <= {PW{1'b0}};
            cnt_r          <= {CW{1'b0}};
`ifdef SPI_ARB_LOCK_EN
            lock_r         <= 1'b0;
`endif
        end else begin
            ack         <= ack_nxt_s;
            grant       <= grant_nxt_s;
            rsp_data    <= data_nxt_s;
            rsp_status  <= status_nxt_s;
            spi_trigger <= (state_nxt_s == LAUNCH);
            // Keeps the master in reset one cycle beyond port_reset, and
            // pulses it after an error or busy timeout.
            spi_reset   <= rst_pend_r | abort_s;
            rst_pend_r  <= 1'b0;
            ptr_r       <= ptr_nxt_s;
            owner_r     <= owner_nxt_s;
            cnt_r       <= cnt_nxt_s;
`ifdef SPI_ARB_LOCK_EN
            lock_r      <= lock_nxt_s;
`endif
            // Config only changes on a new grant, so the master sees stable
            // settings for the whole transaction.
            if (load_cfg_s) begin
                spi_prescaler  <= sel_pre_s;
                spi_data_count <= sel_cnt_s;
                spi_cpol       <= req_cpol[sel_idx_s];
                spi_cpha       <= req_cpha[sel_idx_s];
                spi_dir        <= req_dir[sel_idx_s];
                spi_data_out   <= sel_data_s;
            end else begin
                spi_prescaler  <= spi_prescaler;
                spi_data_count <= spi_data_count;
                spi_cpol       <= spi_cpol;
                spi_cpha       <= spi_cpha;
                spi_dir        <= spi_dir;
                spi_data_out   <= spi_data_out;
            end
        end
    end

endmodule
